// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite master: buffers single-word read/write commands in a FIFO, issues them as
// pipelined SINGLE transfers and returns one response per completed transfer.
`timescale 1ns/1ps
module ahb_lite_cmd_master #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [3:0]  HPROT_V = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] M_AHB_0_haddr,
  output logic [2:0]  M_AHB_0_hburst,
  output logic        M_AHB_0_hmastlock,
  output logic [3:0]  M_AHB_0_hprot,
  output logic [2:0]  M_AHB_0_hsize,
  output logic [1:0]  M_AHB_0_htrans,
  output logic        M_AHB_0_hwrite,
  output logic [31:0] M_AHB_0_hwdata,
  input  logic [31:0] M_AHB_0_hrdata,
  input  logic        M_AHB_0_hready,
  input  logic        M_AHB_0_hresp
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [1:0]  HT_IDLE  = 2'b00;
  localparam logic [1:0]  HT_NSEQ  = 2'b10;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  cmd_t          fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  cmd_t          head_s;
  logic          fifo_empty_s, fifo_full_s, push_s, pop_s;

  // A stage: haddr_q/hwrite_q double as the address-phase command fields.
  logic        a_valid_q, a_valid_d;
  logic        a_mask_q, a_mask_d;
  logic [31:0] a_wdata_q, a_wdata_d;
  logic        d_valid_q, d_valid_d;
  logic        d_write_q, d_write_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  assign head_s       = fifo_q[rd_ptr_q];
  assign fifo_empty_s = (count_q == '0);
  assign fifo_full_s  = (count_q == FULL_CNT);
  assign push_s       = cmd_valid && !fifo_full_s;
  assign pop_s        = M_AHB_0_hready && !a_mask_q && !fifo_empty_s;

  // FIFO storage
  always_ff @(posedge HCLK) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next state of the address/data pipeline, bus outputs and response
  always_comb begin
    a_valid_d   = a_valid_q;
    a_mask_d    = a_mask_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_rdata_d = 32'h0000_0000;
    rsp_err_d   = 1'b0;
    if (M_AHB_0_hready) begin
      if (d_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_write_d = d_write_q;
        rsp_rdata_d = d_write_q ? 32'h0000_0000 : M_AHB_0_hrdata;
        rsp_err_d   = M_AHB_0_hresp;
      end else begin
        rsp_valid_d = 1'b0;
      end
      // A masked command was never seen by the slave: re-drive it instead of advancing.
      if (a_mask_q) begin
        a_mask_d  = 1'b0;
        d_valid_d = 1'b0;
        htrans_d  = HT_NSEQ;
      end else begin
        d_valid_d = a_valid_q;
        if (a_valid_q) begin
          d_write_d = hwrite_q;
          hwdata_d  = a_wdata_q;
        end else begin
          d_write_d = d_write_q;
        end
        if (!fifo_empty_s) begin
          a_valid_d = 1'b1;
          a_wdata_d = head_s.wdata;
          haddr_d   = head_s.addr;
          hwrite_d  = head_s.write;
          htrans_d  = HT_NSEQ;
        end else begin
          a_valid_d = 1'b0;
          htrans_d  = HT_IDLE;
        end
      end
    end else if (M_AHB_0_hresp && d_valid_q && a_valid_q) begin
      a_mask_d = 1'b1;
      htrans_d = HT_IDLE;
    end else begin
      a_mask_d = a_mask_q;
    end
  end

  // Pipeline, bus and response registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid_q   <= 1'b0;
      a_mask_q    <= 1'b0;
      a_wdata_q   <= 32'h0000_0000;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      htrans_q    <= HT_IDLE;
      haddr_q     <= 32'h0000_0000;
      hwrite_q    <= 1'b0;
      hwdata_q    <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_mask_q    <= a_mask_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready         = !fifo_full_s;
  assign busy              = !fifo_empty_s || a_valid_q || d_valid_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_write         = rsp_write_q;
  assign rsp_rdata         = rsp_rdata_q;
  assign rsp_err           = rsp_err_q;
  assign M_AHB_0_haddr     = haddr_q;
  assign M_AHB_0_hburst    = 3'b000;
  assign M_AHB_0_hmastlock = 1'b0;
  assign M_AHB_0_hprot     = HPROT_V;
  assign M_AHB_0_hsize     = 3'b010;
  assign M_AHB_0_htrans    = htrans_q;
  assign M_AHB_0_hwrite    = hwrite_q;
  assign M_AHB_0_hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Bench for ahb_lite_cmd_master: AHB slave model (8 operand regs, product of regs 0..2
// at 0x20, two-cycle error at 0x40) plus a response scoreboard.
`timescale 1ns/1ps
module tb_ahb_lite_cmd_master;

  localparam logic [1:0]  IDLE     = 2'b00;
  localparam logic [1:0]  NONSEQ   = 2'b10;
  localparam logic [31:0] ERR_ADDR = 32'h0000_0040;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0, cmd_wdata = 32'h0;
  logic        rsp_valid, rsp_write, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] haddr, hwdata;
  logic [31:0] hrdata = 32'h0;
  logic [2:0]  hburst, hsize;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock, hwrite;
  logic        hready = 1'b1, hresp = 1'b0;

  always #5 HCLK = ~HCLK;

  ahb_lite_cmd_master #(.DEPTH(4), .HPROT_V(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .M_AHB_0_haddr(haddr), .M_AHB_0_hburst(hburst), .M_AHB_0_hmastlock(hmastlock),
    .M_AHB_0_hprot(hprot), .M_AHB_0_hsize(hsize), .M_AHB_0_htrans(htrans),
    .M_AHB_0_hwrite(hwrite), .M_AHB_0_hwdata(hwdata), .M_AHB_0_hrdata(hrdata),
    .M_AHB_0_hready(hready), .M_AHB_0_hresp(hresp)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t exp_q[$];

  // Expected register contents, updated in command order
  logic [31:0] shadow [8] = '{default: 32'h0};

  // Slave model state (owned by the slave process)
  logic [31:0] mem [8] = '{default: 32'h0};
  logic        force_stall = 1'b0;
  logic [31:0] wait_addr = 32'hFFFF_FFFF;
  int          wait_n = 0;
  logic        lap_valid = 1'b0, lap_write = 1'b0, dp_valid = 1'b0, dp_write = 1'b0;
  logic [31:0] lap_addr = 32'h0, dp_addr = 32'h0;
  logic        last_hready = 1'b1;
  int          dp_wait = 0, err_stage = 0, run = 0, last_run = 0, wr18_count = 0;

  function automatic logic [31:0] reg_read(input logic [31:0] a, input logic [31:0] r0,
                                           input logic [31:0] r1, input logic [31:0] r2,
                                           input logic [31:0] rx);
    if (a == 32'h20) return r0 * r1 * r2;
    else if (a < 32'h20) return rx;
    else return 32'h0;
  endfunction

  // Slave: decides hready/hresp/hrdata for the coming edge from the current data phase
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      dp_valid = 1'b0; lap_valid = 1'b0; last_hready = 1'b1; err_stage = 0; dp_wait = 0;
      hready = 1'b1; hresp = 1'b0; hrdata = 32'h0; run = 0;
    end else begin
      if (last_hready) begin
        dp_valid  = lap_valid;
        dp_addr   = lap_addr;
        dp_write  = lap_write;
        err_stage = 0;
        dp_wait   = (lap_valid && lap_write && lap_addr == wait_addr) ? wait_n : 0;
      end
      hresp  = 1'b0;
      hrdata = 32'hDEAD_BEEF;
      if (force_stall) hready = 1'b0;
      else if (!dp_valid) hready = 1'b1;
      else if (dp_addr == ERR_ADDR) begin
        hresp = 1'b1; hrdata = 32'h0;
        hready = (err_stage != 0);
        err_stage = 1;
      end else if (dp_wait > 0) begin
        hready = 1'b0;
        dp_wait--;
      end else begin
        hready = 1'b1;
        if (dp_write) begin
          if (dp_addr < 32'h20) mem[dp_addr[4:2]] = hwdata;
          if (dp_addr == 32'h18) wr18_count++;
        end else begin
          hrdata = reg_read(dp_addr, mem[0], mem[1], mem[2], mem[dp_addr[4:2]]);
        end
      end
      lap_valid = (htrans == NONSEQ);
      lap_addr  = haddr;
      lap_write = hwrite;
      if (lap_valid) run++;
      else begin
        if (run > 0) last_run = run;
        run = 0;
      end
      last_hready = hready;
    end
  end

  int          rsp_count = 0;
  logic [31:0] last_rdata = 32'h0;
  rsp_t        mon_e;

  // Response monitor: pops the scoreboard on every rsp_valid pulse
  always @(negedge HCLK) begin
    if (!HRESETn) exp_q.delete();
    else if (rsp_valid) begin
      rsp_count++;
      if (exp_q.size() == 0) check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check_eq("rsp_write", 32'(rsp_write), 32'(mon_e.write));
        check_eq("rsp_rdata", rsp_rdata, mon_e.rdata);
        check_eq("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        if (!rsp_write) last_rdata = rsp_rdata;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    rsp_t e;
    bit   ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge HCLK);
    end
    check_eq("push_accept", 32'(ok), 32'd1);
    if (ok) begin
      e.write = w;
      e.err   = (a == ERR_ADDR);
      e.rdata = (w || e.err) ? 32'h0 : reg_read(a, shadow[0], shadow[1], shadow[2], shadow[a[4:2]]);
      exp_q.push_back(e);
      if (w && a < 32'h20) shadow[a[4:2]] = d;
      @(posedge HCLK);
      @(negedge HCLK);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge HCLK);
      if (!busy && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  int base;

  initial begin
    repeat (3) @(negedge HCLK);
    check_eq("rst_htrans", 32'(htrans), 32'(IDLE));
    check_eq("rst_haddr", haddr, 32'h0);
    check_eq("rst_hwdata", hwdata, 32'h0);
    check_eq("rst_hwrite", 32'(hwrite), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("hburst", 32'(hburst), 32'd0);
    check_eq("hsize", 32'(hsize), 32'd2);
    check_eq("hprot", 32'(hprot), 32'd3);
    check_eq("hmastlock", 32'(hmastlock), 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // 1: single write, latency
    send(1'b1, 32'h00, 32'h3);
    @(negedge HCLK);
    check_eq("t1_htrans", 32'(htrans), 32'(NONSEQ));
    check_eq("t1_haddr", haddr, 32'h00);
    check_eq("t1_hwrite", 32'(hwrite), 32'd1);
    @(negedge HCLK);
    check_eq("t1_hwdata", hwdata, 32'h3);
    check_eq("t1_idle", 32'(htrans), 32'(IDLE));
    @(negedge HCLK);
    check_eq("t1_rsp_latency", 32'(rsp_valid), 32'd1);
    drain("t1_drain");

    // 2: back-to-back writes then product read
    send(1'b1, 32'h00, 32'd2);
    send(1'b1, 32'h04, 32'd3);
    send(1'b1, 32'h08, 32'd4);
    send(1'b0, 32'h20, 32'h0);
    drain("t2_drain");
    check_eq("t2_nonseq_run", 32'(last_run), 32'd4);
    check_eq("t2_product", last_rdata, 32'd24);

    // 3: three wait states in a write data phase
    wait_addr = 32'h0C; wait_n = 3;
    base = rsp_count;
    send(1'b1, 32'h0C, 32'h1234);
    send(1'b0, 32'h0C, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      check_eq("t3_htrans", 32'(htrans), 32'(NONSEQ));
      check_eq("t3_haddr", haddr, 32'h0C);
      check_eq("t3_hwdata", hwdata, 32'h1234);
      check_eq("t3_no_rsp", 32'(rsp_valid), 32'd0);
    end
    drain("t3_drain");
    check_eq("t3_rsp_count", 32'(rsp_count - base), 32'd2);
    wait_n = 0;

    // 4: fill the FIFO with the bus stalled, then release
    force_stall = 1'b1;
    repeat (2) @(negedge HCLK);
    send(1'b1, 32'h10, 32'h11);
    send(1'b0, 32'h10, 32'h0);
    send(1'b1, 32'h10, 32'h22);
    send(1'b0, 32'h10, 32'h0);
    check_eq("t4_full", 32'(cmd_ready), 32'd0);
    check_eq("t4_busy", 32'(busy), 32'd1);
    force_stall = 1'b0;
    send(1'b1, 32'h14, 32'h55);
    drain("t4_drain");

    // 5: error response on read, following write issued once
    base = wr18_count;
    send(1'b0, ERR_ADDR, 32'h0);
    send(1'b1, 32'h18, 32'h77);
    drain("t5_drain");
    check_eq("t5_write_once", 32'(wr18_count - base), 32'd1);
    send(1'b0, 32'h18, 32'h0);
    drain("t5_readback");

    // 6: reset with commands in flight
    wait_addr = 32'h1C; wait_n = 50;
    send(1'b1, 32'h1C, 32'h99);
    send(1'b0, 32'h00, 32'h0);
    send(1'b0, 32'h04, 32'h0);
    repeat (2) @(negedge HCLK);
    check_eq("t6_pre_busy", 32'(busy), 32'd1);
    base = rsp_count;
    HRESETn = 1'b0;
    #1;
    check_eq("t6_htrans", 32'(htrans), 32'(IDLE));
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge HCLK);
    wait_n = 0;
    HRESETn = 1'b1;
    repeat (10) @(negedge HCLK);
    check_eq("t6_no_rsp", 32'(rsp_count - base), 32'd0);
    check_eq("t6_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
